// File: rtl/ms_alarm.sv
// Millisecond alarm timer: counts ticks of an external free-running ms counter and
// raises one-shot or periodic expiries with sticky expired/overrun flags.
module ms_alarm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] cnt_i,
  input  logic        start_i,
  input  logic [15:0] period_ms_i,
  input  logic        periodic_i,
  input  logic        stop_i,
  input  logic        irq_ack_i,
  output logic        busy_o,
  output logic [15:0] remaining_ms_o,
  output logic        expire_pulse_o,
  output logic        expired_o,
  output logic        overrun_o,
  output logic        start_err_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        cnt_valid_q;
  logic [15:0] period_q;
  logic        periodic_q;
  logic [15:0] remaining_q;
  logic        expire_pulse_q;
  logic        expired_q;
  logic        overrun_q;
  logic        start_err_q;
  logic        tick;

  // Any change of the ms count is one tick, including wrap and multi-count jumps.
  assign tick = cnt_valid_q & (cnt_i != cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      cnt_valid_q    <= 1'b0;
      period_q       <= '0;
      periodic_q     <= 1'b0;
      remaining_q    <= '0;
      expire_pulse_q <= 1'b0;
      expired_q      <= 1'b0;
      overrun_q      <= 1'b0;
      start_err_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_i;
      cnt_valid_q    <= 1'b1;
      expire_pulse_q <= 1'b0;
      start_err_q    <= 1'b0;
      if (irq_ack_i) begin
        expired_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (stop_i) begin
        state_q     <= StIdle;
        remaining_q <= '0;
      end else if (start_i && (period_ms_i == 16'd0)) begin
        // Rejected start freezes the timer for this cycle, tick included.
        start_err_q <= 1'b1;
      end else if (start_i) begin
        state_q     <= StRun;
        period_q    <= period_ms_i;
        periodic_q  <= periodic_i;
        remaining_q <= period_ms_i;
      end else if ((state_q == StRun) && tick) begin
        if (remaining_q > 16'd1) begin
          remaining_q <= remaining_q - 16'd1;
        end else begin
          expire_pulse_q <= 1'b1;
          expired_q      <= 1'b1;
          // An expiry coinciding with irq_ack wins the flag but never flags overrun.
          if (expired_q && !irq_ack_i) begin
            overrun_q <= 1'b1;
          end
          if (periodic_q) begin
            remaining_q <= period_q;
          end else begin
            remaining_q <= '0;
            state_q     <= StIdle;
          end
        end
      end
    end
  end

  assign busy_o         = (state_q == StRun);
  assign remaining_ms_o = remaining_q;
  assign expire_pulse_o = expire_pulse_q;
  assign expired_o      = expired_q;
  assign overrun_o      = overrun_q;
  assign start_err_o    = start_err_q;

endmodule

// File: tb/tb_ms_alarm.sv
// Bench for ms_alarm: directed vector table, hand-written wrap/reset sequences and
// randomized traffic against a behavioural model of the alarm rules.
module tb_ms_alarm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cnt;
  logic        start, stop, ack, periodic;
  logic [15:0] period;
  logic        busy, ep, expired, overrun, serr;
  logic [15:0] rem;

  int n_checks = 0;
  int n_fail   = 0;

  ms_alarm u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cnt_i         (cnt),
    .start_i       (start),
    .period_ms_i   (period),
    .periodic_i    (periodic),
    .stop_i        (stop),
    .irq_ack_i     (ack),
    .busy_o        (busy),
    .remaining_ms_o(rem),
    .expire_pulse_o(ep),
    .expired_o     (expired),
    .overrun_o     (overrun),
    .start_err_o   (serr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic b, input logic [15:0] r, input logic p,
                     input logic ex, input logic ov, input logic se);
    logic [20:0] act, req;
    act = {busy, rem, ep, expired, overrun, serr};
    req = {b, r, p, ex, ov, se};
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got busy=%0b rem=%0d ep=%0b exp=%0b ovr=%0b serr=%0b, required busy=%0b rem=%0d ep=%0b exp=%0b ovr=%0b serr=%0b",
               name, busy, rem, ep, expired, overrun, serr, b, r, p, ex, ov, se);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; ack = 0; period = '0; periodic = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic st; logic sp; logic ak; logic [15:0] per; logic pdc; logic inc;
    logic b; logic [15:0] r; logic p; logic ex; logic ov; logic se;
  } vec_t;

  vec_t tbl[26];

  // Behavioural reference for the randomized phase.
  bit          m_valid, m_run, m_pdc, m_exp, m_ovr, m_ep, m_se;
  int unsigned m_cnt, m_rem, m_per;

  task automatic model_reset();
    m_valid = 0; m_cnt = 0; m_run = 0; m_rem = 0; m_per = 0; m_pdc = 0;
    m_exp = 0; m_ovr = 0; m_ep = 0; m_se = 0;
  endtask

  task automatic model_step();
    bit tk, old_exp;
    tk = m_valid && (cnt != m_cnt);
    m_cnt = cnt; m_valid = 1; m_ep = 0; m_se = 0; old_exp = m_exp;
    if (ack) begin m_exp = 0; m_ovr = 0; end
    if (stop) begin
      m_run = 0; m_rem = 0;
    end else if (start) begin
      if (period == 0) m_se = 1;
      else begin m_run = 1; m_per = period; m_pdc = periodic; m_rem = period; end
    end else if (m_run && tk) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_ep = 1; m_exp = 1;
        if (old_exp && !ack) m_ovr = 1;
        if (m_pdc) m_rem = m_per;
        else m_run = 0;
      end
    end
  endtask

  initial begin
    //            st sp ak per pdc inc | b  rem ep ex ov se
    tbl[0]  = '{1, 0, 0, 16'd3, 0, 0,  1, 16'd3, 0, 0, 0, 0};  // one-shot 3
    tbl[1]  = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd2, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 16'd0, 0, 1,  0, 16'd0, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 16'd0, 0, 0,  0, 16'd0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 16'd0, 0, 0,  0, 16'd0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 16'd2, 1, 0,  1, 16'd2, 0, 0, 0, 0};  // periodic 2
    tbl[7]  = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd2, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd1, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd2, 1, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 16'd0, 0, 0,  1, 16'd2, 0, 1, 1, 0};
    tbl[12] = '{0, 0, 1, 16'd0, 0, 0,  1, 16'd2, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 16'd5, 0, 0,  0, 16'd0, 0, 0, 0, 0};  // start+stop
    tbl[14] = '{1, 0, 0, 16'd0, 0, 0,  0, 16'd0, 0, 0, 0, 1};  // zero period
    tbl[15] = '{1, 0, 0, 16'd2, 0, 0,  1, 16'd2, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd1, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 16'd0, 0, 1,  0, 16'd0, 1, 1, 0, 0};
    tbl[18] = '{1, 0, 0, 16'd1, 0, 0,  1, 16'd1, 0, 1, 0, 0};
    tbl[19] = '{0, 0, 1, 16'd0, 0, 1,  0, 16'd0, 1, 1, 0, 0};  // ack vs expiry
    tbl[20] = '{1, 0, 0, 16'd4, 1, 0,  1, 16'd4, 0, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 16'd0, 0, 1,  1, 16'd3, 0, 1, 0, 0};
    tbl[22] = '{1, 0, 0, 16'd7, 1, 1,  1, 16'd7, 0, 1, 0, 0};  // restart vs tick
    tbl[23] = '{0, 1, 0, 16'd0, 0, 0,  0, 16'd0, 0, 1, 0, 0};
    tbl[24] = '{0, 0, 0, 16'd0, 0, 1,  0, 16'd0, 0, 1, 0, 0};  // idle tick
    tbl[25] = '{0, 0, 1, 16'd0, 0, 0,  0, 16'd0, 0, 0, 0, 0};

    idle_inputs();
    cnt   = 32'h1234;
    rst_n = 1'b0;
    #1 chk("reset_hold", 0, 16'd0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("reset_release", 0, 16'd0, 0, 0, 0, 0);
    cyc();
    chk("post_release_idle", 0, 16'd0, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; ack = tbl[i].ak;
      period = tbl[i].per; periodic = tbl[i].pdc;
      if (tbl[i].inc) cnt = cnt + 32'd1;
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].b, tbl[i].r, tbl[i].p, tbl[i].ex, tbl[i].ov, tbl[i].se);
    end
    idle_inputs();

    // Wrap through zero: exactly one expiry, on the change to 0.
    cnt = 32'hFFFF_FFFE;
    cyc();
    start = 1; period = 16'd2;
    cyc();
    idle_inputs();
    chk("wrap_start", 1, 16'd2, 0, 0, 0, 0);
    cnt = 32'hFFFF_FFFF;
    cyc();
    chk("wrap_ffff", 1, 16'd1, 0, 0, 0, 0);
    cnt = 32'h0;
    cyc();
    chk("wrap_zero", 0, 16'd0, 1, 1, 0, 0);
    cyc();
    chk("wrap_after", 0, 16'd0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a run.
    start = 1; period = 16'd5; periodic = 1; ack = 1;
    cyc();
    idle_inputs();
    chk("run5", 1, 16'd5, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, 16'd0, 0, 0, 0, 0);
    cnt = cnt + 32'd1;
    cyc();
    chk("reset_held_tick", 0, 16'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    chk("reset_rel2", 0, 16'd0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    rst_n = 1'b0;
    cnt   = 32'hFFFF_FFF0;
    #1 model_reset();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      period   = 16'($urandom_range(0, 4));
      periodic = $urandom_range(0, 1);
      stop     = ($urandom_range(0, 19) == 0);
      ack      = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0, 1: cnt = cnt + 32'd1;
        2:    cnt = cnt + 32'd3;
        default: ;
      endcase
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d", i), m_run, 16'(m_rem), m_ep, m_exp, m_ovr, m_se);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ms_alarm.md
MS_ALARM -- requirements
Module: ms_alarm

Interface
REQ-001 clk  in  1  system clock, same domain as the free-running ms counter; all state updates on the rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
REQ-003 cnt  in  32  free-running millisecond count; increments by exactly 1 per ms and wraps 0xFFFFFFFF->0.
REQ-004 start  in  1  one-cycle request to arm the alarm with period_ms and periodic.
REQ-005 period_ms  in  16  alarm period in ms; sampled only on an accepted start.
REQ-006 periodic  in  1  sampled with start; 1 = auto-reload, 0 = one-shot.
REQ-007 stop  in  1  one-cycle request to disarm.
REQ-008 irq_ack  in  1  one-cycle acknowledge; clears expired and overrun.
REQ-009 busy  out  1  1 while state = RUN.
REQ-010 remaining_ms  out  16  ms left until next expiry; 0 in IDLE.
REQ-011 expire_pulse  out  1  one-cycle strobe on each expiry.
REQ-012 expired  out  1  sticky flag, set on expiry, cleared by irq_ack.
REQ-013 overrun  out  1  sticky flag, set when expiry occurs while expired already 1.
REQ-014 start_err  out  1  one-cycle strobe when a start is rejected.

Function
REQ-015 Tick detection: the block shall register cnt into cnt_q each cycle; tick = cnt_valid & (cnt != cnt_q).
REQ-016 cnt_valid shall be 0 after reset and shall become 1 at the first edge after reset release, so the first captured cnt never produces a tick.
REQ-017 The wrap 0xFFFFFFFF->0 shall produce exactly one tick, like any other increment.
REQ-018 Each tick shall act at the clock edge following the cnt change (1-cycle latency); any multi-count jump shall still count as a single tick.
REQ-019 FSM states: IDLE and RUN only; encoding is free.
REQ-020 IDLE, start=1, stop=0, period_ms!=0: the block shall latch period_ms and periodic, load remaining_ms=period_ms, and go to RUN.
REQ-021 start=1 with period_ms==0: the block shall pulse start_err for 1 cycle and leave state, remaining_ms and the latched period unchanged.
REQ-022 RUN, start=1 (valid), stop=0: the block shall restart, reloading period, periodic and remaining_ms; a tick in the same cycle shall be ignored.
REQ-023 stop=1 in any state: the block shall go to IDLE and set remaining_ms=0; stop shall take priority over start and tick in the same cycle; expired and overrun shall be unchanged.
REQ-024 RUN, tick, remaining_ms>1: the block shall decrement remaining_ms by 1.
REQ-025 RUN, tick, remaining_ms==1: expiry. The block shall assert expire_pulse for 1 cycle and set expired=1.
REQ-026 On expiry with periodic=1, the block shall reload remaining_ms with the latched period and stay in RUN.
REQ-027 On expiry with periodic=0, the block shall set remaining_ms=0 and go to IDLE.
REQ-028 If expired==1 at expiry and irq_ack==0, the block shall set overrun=1.
REQ-029 irq_ack alone shall clear expired and overrun at the next edge.
REQ-030 irq_ack in the same cycle as an expiry: the expiry wins, leaving expired=1 and overrun=0.
REQ-031 Ticks in IDLE shall have no effect.
REQ-032 remaining_ms arithmetic shall be unsigned 16-bit and shall never underflow below 0.

Reset
REQ-033 While reset=0, the block shall hold state=IDLE, cnt_q=0, cnt_valid=0, latched period=0, periodic=0, remaining_ms=0, busy=0, expire_pulse=0, expired=0, overrun=0, start_err=0.
REQ-034 reset asserted mid-RUN shall abort immediately with no expire_pulse; after release, the block shall accept no start until it is driven again.

Verification
REQ-035 One-shot: start, period_ms=3, periodic=0, then 3 cnt increments -> remaining 3,2,1; expire_pulse 1 cycle after the 3rd change; expired=1, busy=0, remaining_ms=0.
REQ-036 Periodic with overrun: period_ms=2, periodic=1, 4 increments, no ack -> expiries at ticks 2 and 4; overrun=1 after tick 4; irq_ack clears both flags.
REQ-037 Wrap: cnt=0xFFFFFFFE, period_ms=2, two increments through 0 -> exactly one expiry, on the change to 0x00000000.
REQ-038 Collisions: start and stop in the same cycle -> IDLE. irq_ack coinciding with expiry -> expired=1, overrun=0. start coinciding with tick in RUN -> remaining_ms = new period.
REQ-039 Zero period: start, period_ms=0 -> start_err pulse; busy stays 0.
REQ-040 Reset release: cnt=0x1234 at release -> no tick; reset asserted mid-RUN (remaining_ms=5) -> all outputs 0 asynchronously and no expire_pulse.
